// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: data width, opcode map and FSM state encoding.
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 4'd0;
  localparam op_t OP_OR   = 4'd1;
  localparam op_t OP_ADD  = 4'd2;
  localparam op_t OP_SUB  = 4'd3;
  localparam op_t OP_XOR  = 4'd4;
  localparam op_t OP_SLL  = 4'd5;
  localparam op_t OP_SRL  = 4'd6;
  localparam op_t OP_SRA  = 4'd7;
  localparam op_t OP_SLT  = 4'd8;
  localparam op_t OP_SLTU = 4'd9;
  localparam op_t OP_MUL  = 4'd10;
  localparam op_t OP_DIV  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  function automatic logic is_muldiv(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_illegal(input op_t op);
    return op > OP_DIV;
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Down-counter that times the EXEC phase: loadable, decrements on request, flags the last count.
module alu_seq_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // The decrement happening on this edge takes the counter to zero.
  assign zero_next = (count == CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external combinational ALU and holds the response.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SHORT_WAIT  = 1,
  parameter int MULDIV_WAIT = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_cntrl,
  input  logic [DATA_W-1:0] alu_c_lo,
  input  logic [DATA_W-1:0] alu_c_hi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [OP_W-1:0]   rsp_op,
  output logic              err_div0,
  output logic              err_illegal
);

  localparam int MAX_WAIT = (SHORT_WAIT > MULDIV_WAIT) ? SHORT_WAIT : MULDIV_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  state_t            state, state_next;
  logic              accept, capture, rsp_done, tmr_zero_next;
  logic [CNT_W-1:0]  wait_val;
  logic [DATA_W-1:0] cap_lo, cap_hi;
  logic              cap_div0, cap_ill;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign capture   = (state == EXEC) && tmr_zero_next;
  assign rsp_done  = (state == DONE) && rsp_ready;
  assign wait_val  = is_muldiv(req_op) ? CNT_W'(MULDIV_WAIT) : CNT_W'(SHORT_WAIT);

  alu_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clock     (clock),
    .clear     (clear),
    .load      (accept),
    .load_val  (wait_val),
    .dec       (state == EXEC),
    .zero_next (tmr_zero_next)
  );

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)     state_next = EXEC;
      EXEC:    if (tmr_zero_next) state_next = DONE;
      DONE:    if (rsp_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Divide-by-zero and illegal opcodes are resolved here; the ALU result is ignored for them.
  always_comb begin
    cap_lo   = alu_c_lo;
    cap_hi   = '0;
    cap_div0 = 1'b0;
    cap_ill  = 1'b0;
    if (is_illegal(alu_cntrl)) begin
      cap_lo  = '0;
      cap_ill = 1'b1;
    end else if ((alu_cntrl == OP_DIV) && (alu_b == '0)) begin
      cap_lo   = '1;
      cap_hi   = alu_a;
      cap_div0 = 1'b1;
    end else if (is_muldiv(alu_cntrl)) begin
      cap_hi = alu_c_hi;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cntrl   <= '0;
      rsp_valid   <= 1'b0;
      rsp_lo      <= '0;
      rsp_hi      <= '0;
      rsp_op      <= '0;
      err_div0    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a     <= req_a;
        alu_b     <= req_b;
        alu_cntrl <= req_op;
      end
      if (capture) begin
        rsp_valid   <= 1'b1;
        rsp_lo      <= cap_lo;
        rsp_hi      <= cap_hi;
        rsp_op      <= alu_cntrl;
        err_div0    <= cap_div0;
        err_illegal <= cap_ill;
      end else if (rsp_done) begin
        rsp_valid   <= 1'b0;
        err_div0    <= 1'b0;
        err_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed requests push expected responses, a monitor pops and compares.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int SW = 1;
  localparam int MW = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, err_div0, err_illegal;
  logic [31:0] alu_a, alu_b, alu_c_lo, alu_c_hi, rsp_lo, rsp_hi;
  logic [3:0]  alu_cntrl, rsp_op;
  logic [63:0] prod;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  op;
    logic        div0;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  alu_sequencer #(.SHORT_WAIT(SW), .MULDIV_WAIT(MW)) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cntrl   (alu_cntrl),
    .alu_c_lo    (alu_c_lo),
    .alu_c_hi    (alu_c_hi),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_lo      (rsp_lo),
    .rsp_hi      (rsp_hi),
    .rsp_op      (rsp_op),
    .err_div0    (err_div0),
    .err_illegal (err_illegal)
  );

  always #5 clock = ~clock;

  // External ALU; C_HI carries junk for single-word ops and for a zero divisor.
  always_comb begin
    alu_c_lo = '0;
    alu_c_hi = 32'hDEADBEEF;
    prod     = '0;
    case (alu_cntrl)
      4'd0:  alu_c_lo = alu_a & alu_b;
      4'd1:  alu_c_lo = alu_a | alu_b;
      4'd2:  alu_c_lo = alu_a + alu_b;
      4'd3:  alu_c_lo = alu_a - alu_b;
      4'd4:  alu_c_lo = alu_a ^ alu_b;
      4'd5:  alu_c_lo = alu_a << alu_b[4:0];
      4'd6:  alu_c_lo = alu_a >> alu_b[4:0];
      4'd7:  alu_c_lo = $signed(alu_a) >>> alu_b[4:0];
      4'd8:  alu_c_lo = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9:  alu_c_lo = {31'b0, alu_a < alu_b};
      4'd10: begin
        prod     = {32'b0, alu_a} * {32'b0, alu_b};
        alu_c_lo = prod[31:0];
        alu_c_hi = prod[63:32];
      end
      4'd11: begin
        if (alu_b != '0) begin
          alu_c_lo = alu_a / alu_b;
          alu_c_hi = alu_a % alu_b;
        end else begin
          alu_c_lo = 32'h12345678;
          alu_c_hi = 32'h9ABCDEF0;
        end
      end
      default: begin
        alu_c_lo = 32'h55555555;
        alu_c_hi = 32'hAAAAAAAA;
      end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic [3:0] op,
                              input logic div0, input logic ill);
    exp_t e;
    e.lo = lo; e.hi = hi; e.op = op; e.div0 = div0; e.ill = ill;
    return e;
  endfunction

  // Monitor: sample late in the low phase, once inputs driven at the falling edge have settled.
  always @(negedge clock) begin : monitor
    exp_t e;
    #3;
    if (rsp_valid && rsp_ready) begin
      check("rsp_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_lo",      64'(rsp_lo),      64'(e.lo));
        check("rsp_hi",      64'(rsp_hi),      64'(e.hi));
        check("rsp_op",      64'(rsp_op),      64'(e.op));
        check("err_div0",    64'(err_div0),    64'(e.div0));
        check("err_illegal", 64'(err_illegal), 64'(e.ill));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input exp_t e);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clock);
    if (push) sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    check("ready_low_after_accept", 64'(req_ready), 64'd0);
  endtask

  task automatic wait_rsp(input string name, input int w, input bit chk_ready);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      if (chk_ready) check({name, "_ready_busy"}, 64'(req_ready), 64'd0);
      @(negedge clock);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(w));
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input exp_t e, input int w, input bit chk_ready);
    issue(op, a, b, 1'b1, e);
    wait_rsp(name, w, chk_ready);
    @(negedge clock);
    check({name, "_back_to_idle"}, 64'({rsp_valid, req_ready, err_div0, err_illegal}), 64'b0100);
  endtask

  initial begin : stimulus
    bit seen;
    repeat (2) @(negedge clock);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_alu",  {alu_a, alu_b} | 64'(alu_cntrl), 64'd0);
    check("reset_rsp",  {rsp_lo, rsp_hi} | 64'(rsp_op), 64'd0);
    check("reset_err",  64'({err_div0, err_illegal}), 64'd0);
    clear = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    run("add",     4'd2,  32'd5,        32'd7,        mk(32'd12, 32'd0, 4'd2, 1'b0, 1'b0), SW, 1'b0);
    run("mul",     4'd10, 32'h00010000, 32'h00010000, mk(32'd0, 32'd1, 4'd10, 1'b0, 1'b0), MW, 1'b1);
    run("div0",    4'd11, 32'd17,       32'd0,        mk(32'hFFFFFFFF, 32'd17, 4'd11, 1'b1, 1'b0), MW, 1'b0);
    run("div",     4'd11, 32'd100,      32'd7,        mk(32'd14, 32'd2, 4'd11, 1'b0, 1'b0), MW, 1'b0);
    run("and",     4'd0,  32'h0000F0F0, 32'h0000FF00, mk(32'h0000F000, 32'd0, 4'd0, 1'b0, 1'b0), SW, 1'b0);
    run("illegal", 4'd13, 32'd1,        32'd2,        mk(32'd0, 32'd0, 4'd13, 1'b0, 1'b1), SW, 1'b0);

    // Backpressure: response must hold while a stray request is ignored.
    rsp_ready = 1'b0;
    issue(4'd2, 32'd1, 32'd2, 1'b1, mk(32'd3, 32'd0, 4'd2, 1'b0, 1'b0));
    wait_rsp("bp", SW, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_op    = 4'd3;
      req_a     = 32'd9;
      req_b     = 32'd9;
      @(negedge clock);
      check("bp_hold_valid", 64'({rsp_valid, req_ready}), 64'b10);
      check("bp_hold_rsp",   {rsp_lo, rsp_hi}, {32'd3, 32'd0});
      check("bp_hold_ops",   64'({rsp_op, alu_cntrl, err_div0, err_illegal}), 64'({4'd2, 4'd2, 2'b00}));
      check("bp_hold_alu",   {alu_a, alu_b}, {32'd1, 32'd2});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_released", 64'({rsp_valid, req_ready}), 64'b01);

    // Clear in the middle of a divide drops it without a response.
    issue(4'd11, 32'd50, 32'd5, 1'b0, mk(32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("clr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("clr_alu",  {alu_a, alu_b} | 64'(alu_cntrl), 64'd0);
    check("clr_rsp",  {rsp_lo, rsp_hi} | 64'(rsp_op), 64'd0);
    check("clr_err",  64'({err_div0, err_illegal}), 64'd0);
    clear = 1'b0;
    @(negedge clock);
    check("clr_ready_after", 64'(req_ready), 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= rsp_valid;
    end
    check("clr_no_response", 64'(seen), 64'd0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SHORT_WAIT, default 1: EXEC cycles for ops 0-9 and illegal ops (>=1).
REQ-002 SHALL have parameter MULDIV_WAIT, default 4: EXEC cycles for ops 10 (mul) and 11 (div) (>=1).
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-006 SHALL have ports req_op in 4, req_a in 32, req_b in 32: opcode and operands.
REQ-007 SHALL have ports alu_a out 32, alu_b out 32, alu_cntrl out 4: registered drive to the combinational ALU.
REQ-008 SHALL have ports alu_c_lo in 32, alu_c_hi in 32: ALU results.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-010 SHALL have ports rsp_lo out 32, rsp_hi out 32, rsp_op out 4: captured Z_LO/Z_HI and echoed opcode.
REQ-011 SHALL have ports err_div0 out 1, err_illegal out 1: response status, valid while rsp_valid=1.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; reset state IDLE.
REQ-013 req_ready SHALL equal 1 only in IDLE; acceptance = req_valid && req_ready at a rising edge t0.
REQ-014 On acceptance SHALL register req_a/req_b/req_op into alu_a/alu_b/alu_cntrl, load the wait counter with W, enter EXEC.
REQ-015 W SHALL be MULDIV_WAIT for op 10-11, SHORT_WAIT otherwise.
REQ-016 alu_a/alu_b/alu_cntrl SHALL hold constant from t0 until the next acceptance.
REQ-017 EXEC SHALL decrement the counter each cycle; at edge t0+W SHALL capture results, enter DONE, assert rsp_valid.
REQ-018 Capture for ops 0-9: rsp_lo=alu_c_lo, rsp_hi=0 (ALU C_HI not driven for these ops).
REQ-019 Capture for ops 10-11: rsp_lo=alu_c_lo, rsp_hi=alu_c_hi.
REQ-020 Op 11 with alu_b==0: rsp_lo=32'hFFFFFFFF, rsp_hi=alu_a, err_div0=1; ALU outputs ignored.
REQ-021 Ops 12-15: rsp_lo=rsp_hi=0, err_illegal=1, W=SHORT_WAIT.
REQ-022 rsp_op SHALL equal the accepted op from capture until the next capture.
REQ-023 DONE: rsp_valid and all rsp_*/err_* SHALL hold stable until rsp_ready=1; at that edge return to IDLE, rsp_valid=0.
REQ-024 req_valid outside IDLE SHALL be ignored; no queuing (min spacing between acceptances W+2 cycles).
REQ-025 err_div0/err_illegal SHALL clear to 0 on leaving DONE.

Reset
REQ-026 clear=1 at an edge SHALL, from any state, force IDLE, counter=0, rsp_valid=0, rsp_lo=rsp_hi=0, rsp_op=0, err_*=0, alu_a=alu_b=0, alu_cntrl=0.
REQ-027 clear SHALL override simultaneous acceptance or rsp_ready; an in-flight op is dropped with no response.
REQ-028 req_ready SHALL read 1 in the cycle after clear deasserts.

Structure
REQ-029 Package alu_seq_pkg SHALL hold opcode constants OP_AND=0..OP_DIV=11, the state enum, and DATA_W=32.
REQ-030 Wait counter SHALL be a sub-module alu_seq_timer (load, decrement, zero flag); the rest flat.

Verification
REQ-031 ADD (op 2) a=5, b=7, SHORT_WAIT=1 -> rsp_valid at t0+1, rsp_lo=12, rsp_hi=0, err_*=0.
REQ-032 MUL (op 10) a=b=32'h00010000, MULDIV_WAIT=4 -> rsp_valid at t0+4, rsp_lo=0, rsp_hi=1; req_ready=0 from t0 until return to IDLE.
REQ-033 DIV (op 11) a=17, b=0 -> err_div0=1, rsp_lo=32'hFFFFFFFF, rsp_hi=17.
REQ-034 rsp_ready held 0 for 5 cycles, req_valid pulsed meanwhile -> rsp outputs unchanged, pulse not accepted.
REQ-035 clear=1 at t0+2 during DIV -> all outputs 0 next cycle, no rsp_valid, req_ready=1 after clear drops.
REQ-036 op 13 -> err_illegal=1, rsp_lo=rsp_hi=0 at t0+SHORT_WAIT.
